// File: rtl/ice40_ebr_fifo.sv
// Single-clock FIFO on one inferred iCE40 EBR with registered-read prefetch,
// first-word-fall-through output and valid/ready streams on both sides.
module ice40_ebr_fifo #(
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned ADDR_WIDTH  = 9,
   parameter int unsigned AFULL_LEVEL = 448
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  flush,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  almost_full
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
   localparam int unsigned CW    = ADDR_WIDTH + 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] dout_q;

   logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
   logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  out_valid_q, out_valid_d;
   logic                  in_ready_q, in_ready_d;
   logic                  almost_full_q, almost_full_d;

   logic                  clear;
   logic                  push;
   logic                  pop;
   logic                  rd_en;
   logic                  ram_we;
   logic                  ram_re;
   logic [CW-1:0]         ram_words;

   // Handshakes, prefetch decision and next-state for all control flops
   always_comb begin
      wptr_d        = wptr_q;
      rptr_d        = rptr_q;
      count_d       = count_q;
      out_valid_d   = out_valid_q;
      in_ready_d    = in_ready_q;
      almost_full_d = almost_full_q;

      clear     = reset | flush;
      push      = in_valid & in_ready_q;
      pop       = out_valid_q & out_ready;
      ram_words = count_q - CW'(out_valid_q);
      rd_en     = (ram_words != '0) & (~out_valid_q | pop);

      if (push) begin
         wptr_d = wptr_q + ADDR_WIDTH'(1);
      end
      if (rd_en) begin
         rptr_d      = rptr_q + ADDR_WIDTH'(1);
         out_valid_d = 1'b1;
      end else if (pop) begin
         out_valid_d = 1'b0;
      end

      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CW'(1);
      end

      if (clear) begin
         wptr_d      = '0;
         rptr_d      = '0;
         count_d     = '0;
         out_valid_d = 1'b0;
      end

      // Flags are registered from next count so consumers see clean flops
      in_ready_d    = (count_d != CW'(DEPTH));
      almost_full_d = (count_d >= CW'(AFULL_LEVEL));

      ram_we = push & ~clear;
      ram_re = rd_en & ~clear;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wptr_q        <= '0;
         rptr_q        <= '0;
         count_q       <= '0;
         out_valid_q   <= 1'b0;
         in_ready_q    <= 1'b1;
         almost_full_q <= 1'b0;
      end else begin
         wptr_q        <= wptr_d;
         rptr_q        <= rptr_d;
         count_q       <= count_d;
         out_valid_q   <= out_valid_d;
         in_ready_q    <= in_ready_d;
         almost_full_q <= almost_full_d;
      end
   end

   // EBR: plain write port, registered read port with enable (read-during-write returns old data)
   always_ff @(posedge clock) begin
      if (ram_we) begin
         mem[wptr_q] <= in_data;
      end
      if (ram_re) begin
         dout_q <= mem[rptr_q];
      end
   end

   assign in_ready    = in_ready_q;
   assign out_data    = dout_q;
   assign out_valid   = out_valid_q;
   assign count       = count_q;
   assign almost_full = almost_full_q;

endmodule

// File: tb/tb_ice40_ebr_fifo.sv
// Directed self-checking bench for ice40_ebr_fifo; inputs driven and outputs
// sampled on the falling edge, design state changes on the rising edge.
module tb_ice40_ebr_fifo;

   localparam int unsigned DW = 8;
   localparam int unsigned AW = 9;

   logic          clock;
   logic          reset;
   logic          flush;
   logic [DW-1:0] in_data;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic [AW:0]   count;
   logic          almost_full;

   int tests_run;
   int tests_failed;

   ice40_ebr_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_LEVEL(448)) dut (
      .clock       (clock),
      .reset       (reset),
      .flush       (flush),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .count       (count),
      .almost_full (almost_full)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic idle_inputs();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      flush     = 1'b0;
      in_data   = '0;
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h11;
      repeat (3) tick();
      reset    = 1'b0;
      in_valid = 1'b0;
      tests_run++;
      if (count !== 10'd0) begin
         tests_failed++; $display("FAIL reset_count got %0d want 0", count);
      end
      tests_run++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || almost_full !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_flags got ov=%b ir=%b af=%b want ov=0 ir=1 af=0", out_valid, in_ready, almost_full);
      end
      repeat (2) tick();
      tests_run++;
      if (out_valid !== 1'b0 || count !== 10'd0) begin
         tests_failed++; $display("FAIL reset_nostore got ov=%b cnt=%0d want ov=0 cnt=0", out_valid, count);
      end
   endtask

   task automatic test_single();
      in_valid = 1'b1;
      in_data  = 8'hA5;
      tick();
      in_valid = 1'b0;
      tests_run++;
      if (out_valid !== 1'b0 || count !== 10'd1) begin
         tests_failed++; $display("FAIL single_idle got ov=%b cnt=%0d want ov=0 cnt=1", out_valid, count);
      end
      tick();
      for (int i = 0; i < 10; i++) begin
         tests_run++;
         if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
            tests_failed++;
            $display("FAIL single_hold[%0d] got ov=%b data=%h want ov=1 data=a5", i, out_valid, out_data);
         end
         tick();
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      tests_run++;
      if (out_valid !== 1'b0 || count !== 10'd0) begin
         tests_failed++; $display("FAIL single_pop got ov=%b cnt=%0d want ov=0 cnt=0", out_valid, count);
      end
   endtask

   task automatic fill(input int n, input int base);
      out_ready = 1'b0;
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_data  = 8'(base + i);
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic test_fill_drain();
      int af_bad;
      int first_af;
      int got;
      int cyc;
      af_bad   = 0;
      first_af = -1;
      out_ready = 1'b0;
      for (int i = 0; i < 512; i++) begin
         if (almost_full !== (i >= 448)) af_bad++;
         if (almost_full === 1'b1 && first_af < 0) first_af = i;
         in_valid = 1'b1;
         in_data  = 8'(i);
         tick();
      end
      in_valid = 1'b0;
      tests_run++;
      if (af_bad != 0 || first_af != 448) begin
         tests_failed++; $display("FAIL fill_afull first high at %0d (%0d bad) want 448 (0 bad)", first_af, af_bad);
      end
      tests_run++;
      if (count !== 10'd512 || in_ready !== 1'b0 || almost_full !== 1'b1) begin
         tests_failed++;
         $display("FAIL fill_full got cnt=%0d ir=%b af=%b want cnt=512 ir=0 af=1", count, in_ready, almost_full);
      end
      in_valid = 1'b1;
      in_data  = 8'hFF;
      tick();
      in_valid = 1'b0;
      tests_run++;
      if (count !== 10'd512) begin
         tests_failed++; $display("FAIL fill_refuse got cnt=%0d want 512", count);
      end
      out_ready = 1'b1;
      got = 0;
      cyc = 0;
      while (count != 0 && cyc < 2000) begin
         if (out_valid === 1'b1) begin
            tests_run++;
            if (out_data !== 8'(got)) begin
               tests_failed++; $display("FAIL drain[%0d] got %h want %h", got, out_data, 8'(got));
            end
            got++;
         end
         tick();
         cyc++;
      end
      out_ready = 1'b0;
      tests_run++;
      if (got != 512 || count !== 10'd0 || out_valid !== 1'b0) begin
         tests_failed++; $display("FAIL drain_total got %0d words cnt=%0d want 512 words cnt=0", got, count);
      end
   endtask

   task automatic test_stream();
      int sent;
      int rcvd;
      int cyc;
      int bad;
      int over;
      sent = 0;
      rcvd = 0;
      cyc  = 0;
      bad  = 0;
      over = 0;
      while (rcvd < 1500 && cyc < 20000) begin
         in_valid  = (sent < 1500) && ($urandom_range(1, 0) == 1);
         in_data   = 8'(sent);
         out_ready = ($urandom_range(1, 0) == 1);
         if (count > 10'd512) over++;
         if (out_valid === 1'b1 && out_ready) begin
            if (out_data !== 8'(rcvd)) begin
               if (bad < 4) $display("FAIL stream[%0d] got %h want %h", rcvd, out_data, 8'(rcvd));
               bad++;
            end
            rcvd++;
         end
         if (in_valid && in_ready === 1'b1) sent++;
         tick();
         cyc++;
      end
      idle_inputs();
      tests_run++;
      if (bad != 0) begin
         tests_failed++; $display("FAIL stream_order got %0d mismatched words want 0", bad);
      end
      tests_run++;
      if (rcvd != 1500 || over != 0 || count !== 10'd0) begin
         tests_failed++;
         $display("FAIL stream_total got rcvd=%0d over=%0d cnt=%0d want 1500/0/0", rcvd, over, count);
      end
   endtask

   task automatic test_full_pop();
      fill(512, 0);
      tick();
      in_valid  = 1'b1;
      in_data   = 8'h77;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      tests_run++;
      if (count !== 10'd511 || in_ready !== 1'b1) begin
         tests_failed++; $display("FAIL fullpop_refuse got cnt=%0d ir=%b want cnt=511 ir=1", count, in_ready);
      end
      tick();
      in_valid = 1'b0;
      tests_run++;
      if (count !== 10'd512 || in_ready !== 1'b0 || out_data !== 8'd1) begin
         tests_failed++;
         $display("FAIL fullpop_accept got cnt=%0d ir=%b head=%h want cnt=512 ir=0 head=01", count, in_ready, out_data);
      end
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   task automatic test_flush();
      fill(37, 8'h40);
      tick();
      tests_run++;
      if (count !== 10'd37 || out_valid !== 1'b1 || out_data !== 8'h40) begin
         tests_failed++; $display("FAIL flush_pre got cnt=%0d head=%h want cnt=37 head=40", count, out_data);
      end
      flush     = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'h99;
      out_ready = 1'b1;
      tick();
      idle_inputs();
      tests_run++;
      if (count !== 10'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         tests_failed++; $display("FAIL flush_clear got cnt=%0d ov=%b ir=%b want 0/0/1", count, out_valid, in_ready);
      end
      in_valid = 1'b1;
      in_data  = 8'h3C;
      tick();
      in_valid = 1'b0;
      tick();
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== 8'h3C || count !== 10'd1) begin
         tests_failed++;
         $display("FAIL flush_next got ov=%b data=%h cnt=%0d want ov=1 data=3c cnt=1", out_valid, out_data, count);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset        = 1'b0;
      idle_inputs();
      @(negedge clock);
      test_reset();
      test_single();
      test_fill_drain();
      test_stream();
      test_full_pop();
      test_flush();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
